// File: rtl/alu_secuenciador_if.sv
// Control/data bus between the sequencer and one 4-bit Operaciones ALU.
// The sequencer owns every ALU control input (master); the ALU drives done and data back (slave).
interface alu_secuenciador_if;
   logic [7:0] alu_instr;
   logic [3:0] alu_A;
   logic [3:0] alu_B;
   logic       alu_init;
   logic       alu_rd;
   logic       alu_done;
   logic [3:0] alu_dato;

   modport master (
      output alu_instr, alu_A, alu_B, alu_init, alu_rd,
      input  alu_done, alu_dato
   );

   modport slave (
      input  alu_instr, alu_A, alu_B, alu_init, alu_rd,
      output alu_done, alu_dato
   );
endinterface

// File: rtl/alu_secuenciador.sv
// Sequences one Operaciones ALU for a single host: latch operands, run init/done/rd
// handshake with the required hold times, capture the result and pulse valid.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; operands latched on accept
// S_FLUSH   | one rd pulse to clear a done left over from earlier activity
// S_INIT    | alu_init held for INIT_CYCLES cycles
// S_WAIT    | waiting for alu_done, bounded by TIMEOUT cycles
// S_READ    | one rd pulse; ALU updates dato_mux and clears done
// S_CAPT    | capture result, pulse valid, bump op_count
module alu_secuenciador #(
   parameter int INIT_CYCLES = 2,
   parameter int TIMEOUT     = 15,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [7:0]           instr_in,
   input  logic [3:0]           a_in,
   input  logic [3:0]           b_in,
   output logic                 busy,
   output logic                 valid,
   output logic                 error,
   output logic [3:0]           result,
   output logic [CNT_W-1:0]     op_count,
   alu_secuenciador_if.master   alu
);

   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_INIT,
      S_WAIT,
      S_READ,
      S_CAPT
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [INIT_W-1:0]   init_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [7:0]          instr_q;
   logic [3:0]          a_q;
   logic [3:0]          b_q;

   logic                accept;
   logic                init_ld;
   logic                init_dec;
   logic                tmo_ld;
   logic                tmo_dec;
   logic                capt;
   logic                abort;
   logic                init_c;
   logic                rd_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      init_ld   = 1'b0;
      init_dec  = 1'b0;
      tmo_ld    = 1'b0;
      tmo_dec   = 1'b0;
      capt      = 1'b0;
      abort     = 1'b0;
      init_c    = 1'b0;
      rd_c      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (alu.alu_done) begin
                  state_nxt = S_FLUSH;
               end else begin
                  init_ld   = 1'b1;
                  state_nxt = S_INIT;
               end
            end
         end
         S_FLUSH: begin
            rd_c      = 1'b1;
            init_ld   = 1'b1;
            state_nxt = S_INIT;
         end
         S_INIT: begin
            init_c = 1'b1;
            if (init_cnt == '0) begin
               tmo_ld    = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               init_dec = 1'b1;
            end
         end
         S_WAIT: begin
            if (alu.alu_done) begin
               state_nxt = S_READ;
            end else if (tmo_cnt == '0) begin
               abort     = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmo_dec = 1'b1;
            end
         end
         S_READ: begin
            rd_c      = 1'b1;
            state_nxt = S_CAPT;
         end
         S_CAPT: begin
            capt      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Both timers are down-counters loaded with (length - 1) and terminate at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         if (init_ld) begin
            init_cnt <= INIT_W'(INIT_CYCLES - 1);
         end else if (init_dec) begin
            init_cnt <= init_cnt - 1'b1;
         end
         if (tmo_ld) begin
            tmo_cnt <= TMO_W'(TIMEOUT - 1);
         end else if (tmo_dec) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result   <= '0;
         op_count <= '0;
         valid    <= 1'b0;
         error    <= 1'b0;
      end else begin
         valid <= capt;
         error <= abort;
         if (accept) begin
            instr_q <= instr_in;
            a_q     <= a_in;
            b_q     <= b_in;
         end
         if (capt) begin
            // Opcode 7 has no readback path in the ALU, so its dato_mux is meaningless.
            result   <= (instr_q[7:5] == 3'd7) ? 4'h0 : alu.alu_dato;
            op_count <= op_count + 1'b1;
         end
      end
   end

   assign busy          = (state != S_IDLE);
   assign alu.alu_init  = init_c;
   assign alu.alu_rd    = rd_c;
   assign alu.alu_instr = instr_q;
   assign alu.alu_A     = a_q;
   assign alu.alu_B     = b_q;

endmodule
